inst_decode_stage: RTL and testbench

Pipelined RISC-V base-integer instruction decode stage sitting between the fetch unit and the register-read/execute stage. It accepts one 32-bit instruction plus PC per cycle over a valid/ready handshake and classifies the format. It extracts register indices, function fields and a sign-extended immediate, flags illegal encodings and counts them. The stage is parametrised for RV32I/RV64I. It adds a one-entry skid buffer so that `in_ready` is a registered signal and full throughput holds under backpressure.

---
 rtl/inst_decode_stage.sv | 123 ++++++++++++
 tb/tb_inst_decode_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_decode_stage.sv
// inst_decode_stage: RV32I/RV64I instruction decode with registered-ready skid buffer
// Ports: clk, rst (sync, active-high), flush; in_valid/in_ready/in_inst/in_pc from fetch;
//        out_valid/out_ready plus decoded out_* fields to execute; ill_cnt saturating illegal count.
module inst_decode_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [2:0]       out_type,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_rd_we,
    output logic             out_illegal,
    output logic [CNT_W-1:0] ill_cnt
);
    localparam int W = 2 * XLEN + 37;
    localparam logic RV64 = (XLEN == 64);
    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3, T_U = 3'd4, T_J = 3'd5, T_ILL = 3'd7;
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_IMM32 = 7'b0011011,
                           OP_OP = 7'b0110011, OP_OP32 = 7'b0111011, OP_MISC = 7'b0001111,
                           OP_SYSTEM = 7'b1110011;
    logic [6:0] opc, f7, sh_up, sra_up;
    logic [2:0] f3, typ_raw, typ;
    logic [4:0] rs1, rs2, rd;
    logic ill, rd_we;
    logic signed [31:0] imm32;
    logic [XLEN-1:0] imm;
    logic [W-1:0] dec, out_q, out_d, skid_q, skid_d;
    logic out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic in_hs, out_hs, out_free;
    assign opc = in_inst[6:0];
    assign rd  = in_inst[11:7];
    assign f3  = in_inst[14:12];
    assign rs1 = in_inst[19:15];
    assign rs2 = in_inst[24:20];
    assign f7  = in_inst[31:25];
    // Shift-amount upper bits: RV64 uses a 6-bit shamt, so only inst[31:26] must be checked.
    assign sh_up  = RV64 ? {1'b0, in_inst[31:26]} : in_inst[31:25];
    assign sra_up = RV64 ? 7'h10 : 7'h20;
    always_comb begin
        typ_raw = T_R;
        ill = 1'b0;
        case (opc)
            OP_LUI, OP_AUIPC:   typ_raw = T_U;
            OP_JAL:             typ_raw = T_J;
            OP_JALR:            begin typ_raw = T_I; ill = f3 != 3'd0; end
            OP_BRANCH:          begin typ_raw = T_B; ill = f3[2:1] == 2'b01; end
            OP_LOAD:            begin typ_raw = T_I; ill = f3 == 3'b111 || (!RV64 && (f3 == 3'b011 || f3 == 3'b110)); end
            OP_STORE:           begin typ_raw = T_S; ill = f3 > (RV64 ? 3'd3 : 3'd2); end
            OP_IMM:             begin typ_raw = T_I; ill = (f3 == 3'b001 && sh_up != 7'd0) || (f3 == 3'b101 && sh_up != 7'd0 && sh_up != sra_up); end
            OP_IMM32:           begin typ_raw = T_I; ill = !RV64; end
            OP_OP:              ill = !(f7 == 7'h00 || f7 == 7'h20) || (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
            OP_OP32:            ill = !RV64;
            OP_SYSTEM, OP_MISC: typ_raw = T_I;
            default:            ill = 1'b1;
        endcase
    end
    assign imm32 = ill ? 32'sd0 :
                   typ_raw == T_I ? {{20{in_inst[31]}}, in_inst[31:20]} :
                   typ_raw == T_S ? {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]} :
                   typ_raw == T_B ? {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0} :
                   typ_raw == T_U ? {in_inst[31:12], 12'b0} :
                   typ_raw == T_J ? {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0} :
                   32'sd0;
    assign imm   = XLEN'(imm32);
    assign typ   = ill ? T_ILL : typ_raw;
    assign rd_we = !ill && typ_raw != T_S && typ_raw != T_B && rd != 5'd0;
    assign dec   = {in_pc, typ, opc, f3, f7, rs1, rs2, rd, imm, rd_we, ill};
    assign in_hs    = in_valid && in_ready_q;
    assign out_hs   = out_valid_q && out_ready;
    assign out_free = !out_valid_q || out_ready;
    // Skid holds the older entry, so it always drains into the output before new input.
    always_comb begin
        out_valid_d  = out_free ? (skid_valid_q || in_hs) : out_valid_q;
        out_d        = out_free ? (skid_valid_q ? skid_q : (in_hs ? dec : out_q)) : out_q;
        skid_valid_d = out_free ? (skid_valid_q && in_hs) : (skid_valid_q || in_hs);
        skid_d       = in_hs && (skid_valid_q || !out_free) ? dec : skid_q;
        cnt_d        = out_hs && out_illegal && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
            cnt_d        = cnt_q;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
            cnt_q        <= '0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= !skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end
    assign {out_pc, out_type, out_opcode, out_funct3, out_funct7, out_rs1, out_rs2, out_rd, out_imm, out_rd_we, out_illegal} = out_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign ill_cnt   = cnt_q;
endmodule

// File: tb/tb_inst_decode_stage.sv
// tb_inst_decode_stage: directed checks of decode, skid buffering, flush and illegal counting
module tb_inst_decode_stage;
    logic clk = 1'b0, rst = 1'b1, flush = 1'b0, out_ready = 1'b0, v32 = 1'b0, v64 = 1'b0;
    logic [31:0] inst = '0, pc32 = '0;
    logic [63:0] pc64 = '0;
    logic r32, ov32, we32, il32, r64, ov64, we64, il64;
    logic [31:0] pco32, imm32;
    logic [63:0] pco64, imm64;
    logic [2:0] ty32, f3_32, ty64, f3_64;
    logic [6:0] op32, f7_32, op64, f7_64;
    logic [4:0] rs1_32, rs2_32, rd32, rs1_64, rs2_64, rd64;
    logic [15:0] cnt32;
    logic [1:0] cnt64;
    int n_cmp = 0, n_bad = 0;

    always #5 clk = ~clk;

    inst_decode_stage #(.XLEN(32), .CNT_W(16)) d32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v32), .in_ready(r32), .in_inst(inst), .in_pc(pc32),
        .out_valid(ov32), .out_ready(out_ready), .out_pc(pco32), .out_type(ty32), .out_opcode(op32),
        .out_funct3(f3_32), .out_funct7(f7_32), .out_rs1(rs1_32), .out_rs2(rs2_32), .out_rd(rd32),
        .out_imm(imm32), .out_rd_we(we32), .out_illegal(il32), .ill_cnt(cnt32));

    inst_decode_stage #(.XLEN(64), .CNT_W(2)) d64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(v64), .in_ready(r64), .in_inst(inst), .in_pc(pc64),
        .out_valid(ov64), .out_ready(out_ready), .out_pc(pco64), .out_type(ty64), .out_opcode(op64),
        .out_funct3(f3_64), .out_funct7(f7_64), .out_rs1(rs1_64), .out_rs2(rs2_64), .out_rd(rd64),
        .out_imm(imm64), .out_rd_we(we64), .out_illegal(il64), .ill_cnt(cnt64));

    task automatic test_reset;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({r32, ov32, cnt32, ty32, imm32, pco32, rd32, we32, r64, ov64, cnt64, imm64} !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got rdy=%b v=%b cnt=%0d type=%0d imm=%h rdy64=%b v64=%b, want all 0",
                     r32, ov32, cnt32, ty32, imm32, r64, ov64);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({r32, r64, ov32} !== 3'b110) begin
            n_bad++;
            $display("FAIL reset_ready: got r32=%b r64=%b v=%b, want 1 1 0", r32, r64, ov32);
        end
    endtask

    task automatic test_addi;
        out_ready = 1'b1; v32 = 1'b1; inst = 32'hFFF00093; pc32 = 32'h100;
        @(negedge clk);
        v32 = 1'b0;
        n_cmp++;
        if ({ov32, pco32, ty32, rd32, rs1_32, imm32, we32, il32} !== {1'b1, 32'h100, 3'd1, 5'd1, 5'd0, 32'hFFFFFFFF, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL addi: got v=%b pc=%h type=%0d rd=%0d rs1=%0d imm=%h we=%b ill=%b, want 1 100 1 1 0 ffffffff 1 0",
                     ov32, pco32, ty32, rd32, rs1_32, imm32, we32, il32);
        end
    endtask

    task automatic test_store;
        v32 = 1'b1; inst = 32'h0020A423; pc32 = 32'h104;
        @(negedge clk);
        v32 = 1'b0;
        n_cmp++;
        if ({ov32, ty32, rs1_32, rs2_32, f3_32, imm32, we32, il32} !== {1'b1, 3'd2, 5'd1, 5'd2, 3'd2, 32'd8, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL store: got v=%b type=%0d rs1=%0d rs2=%0d f3=%0d imm=%h we=%b ill=%b, want 1 2 1 2 2 8 0 0",
                     ov32, ty32, rs1_32, rs2_32, f3_32, imm32, we32, il32);
        end
        @(negedge clk);
        n_cmp++;
        if (ov32 !== 1'b0) begin
            n_bad++;
            $display("FAIL store_drain: got out_valid=%b, want 0", ov32);
        end
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b0; v32 = 1'b1; inst = 32'h00100093;
        @(negedge clk);
        n_cmp++;
        if ({r32, ov32, rd32} !== {1'b1, 1'b1, 5'd1}) begin
            n_bad++;
            $display("FAIL b2b_first: got rdy=%b v=%b rd=%0d, want 1 1 1", r32, ov32, rd32);
        end
        inst = 32'h00200113;
        @(negedge clk);
        n_cmp++;
        if ({r32, ov32, rd32} !== {1'b0, 1'b1, 5'd1}) begin
            n_bad++;
            $display("FAIL b2b_skid_full: got rdy=%b v=%b rd=%0d, want 0 1 1", r32, ov32, rd32);
        end
        inst = 32'h00300193;
        @(negedge clk);
        n_cmp++;
        if ({r32, ov32, rd32, imm32} !== {1'b0, 1'b1, 5'd1, 32'd1}) begin
            n_bad++;
            $display("FAIL b2b_stall_stable: got rdy=%b v=%b rd=%0d imm=%h, want 0 1 1 1", r32, ov32, rd32, imm32);
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({r32, ov32, rd32, imm32} !== {1'b1, 1'b1, 5'd2, 32'd2}) begin
            n_bad++;
            $display("FAIL b2b_second: got rdy=%b v=%b rd=%0d imm=%h, want 1 1 2 2", r32, ov32, rd32, imm32);
        end
        @(negedge clk);
        v32 = 1'b0;
        n_cmp++;
        if ({ov32, rd32, imm32} !== {1'b1, 5'd3, 32'd3}) begin
            n_bad++;
            $display("FAIL b2b_third: got v=%b rd=%0d imm=%h, want 1 3 3", ov32, rd32, imm32);
        end
        @(negedge clk);
        n_cmp++;
        if (ov32 !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: got out_valid=%b, want 0", ov32);
        end
    endtask

    task automatic test_illegal;
        out_ready = 1'b1; v32 = 1'b1; inst = 32'h00000000;
        @(negedge clk);
        n_cmp++;
        if ({ov32, ty32, we32, imm32, il32, cnt32} !== {1'b1, 3'd7, 1'b0, 32'd0, 1'b1, 16'd0}) begin
            n_bad++;
            $display("FAIL ill_zero: got v=%b type=%0d we=%b imm=%h ill=%b cnt=%0d, want 1 7 0 0 1 0",
                     ov32, ty32, we32, imm32, il32, cnt32);
        end
        inst = 32'h0010009B;
        @(negedge clk);
        v32 = 1'b0;
        n_cmp++;
        if ({ty32, we32, imm32, il32, rd32, op32, cnt32} !== {3'd7, 1'b0, 32'd0, 1'b1, 5'd1, 7'h1B, 16'd1}) begin
            n_bad++;
            $display("FAIL ill_addiw32: got type=%0d we=%b imm=%h ill=%b rd=%0d op=%h cnt=%0d, want 7 0 0 1 1 1b 1",
                     ty32, we32, imm32, il32, rd32, op32, cnt32);
        end
        @(negedge clk);
        n_cmp++;
        if ({ov32, cnt32} !== {1'b0, 16'd2}) begin
            n_bad++;
            $display("FAIL ill_count: got v=%b cnt=%0d, want 0 2", ov32, cnt32);
        end
    endtask

    task automatic test_flush;
        out_ready = 1'b0; v32 = 1'b1; inst = 32'h00000000;
        @(negedge clk);
        inst = 32'h00100093;
        @(negedge clk);
        n_cmp++;
        if ({ov32, r32, il32} !== 3'b101) begin
            n_bad++;
            $display("FAIL flush_full: got v=%b rdy=%b ill=%b, want 1 0 1", ov32, r32, il32);
        end
        flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0; v32 = 1'b0;
        n_cmp++;
        if ({ov32, r32, cnt32} !== {1'b0, 1'b1, 16'd2}) begin
            n_bad++;
            $display("FAIL flush_clear: got v=%b rdy=%b cnt=%0d, want 0 1 2", ov32, r32, cnt32);
        end
        v32 = 1'b1; flush = 1'b1; inst = 32'h00500293;
        @(negedge clk);
        v32 = 1'b0; flush = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ov32, r32} !== 2'b01) begin
            n_bad++;
            $display("FAIL flush_discard: got v=%b rdy=%b, want 0 1", ov32, r32);
        end
    endtask

    task automatic test_fields;
        logic [31:0] vi [10];
        logic [2:0]  vt [10];
        vi = '{32'h00208033, 32'h40208033, 32'h40209033, 32'h02208033, 32'h000010E7,
               32'h00002063, 32'h00003083, 32'h00003023, 32'h02009093, 32'h4010D093};
        vt = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd1};
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            v32 = 1'b1; inst = vi[i];
            @(negedge clk);
            v32 = 1'b0;
            n_cmp++;
            if ({ov32, ty32, il32} !== {1'b1, vt[i], vt[i] == 3'd7}) begin
                n_bad++;
                $display("FAIL field_%0d (%h): got v=%b type=%0d ill=%b, want 1 %0d %b",
                         i, vi[i], ov32, ty32, il32, vt[i], vt[i] == 3'd7);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (cnt32 !== 16'd9) begin
            n_bad++;
            $display("FAIL field_count: got cnt=%0d, want 9", cnt32);
        end
    endtask

    task automatic test_rv64;
        out_ready = 1'b1; v64 = 1'b1; inst = 32'h800000B7; pc64 = 64'h8000_0000_0000_0010;
        @(negedge clk);
        n_cmp++;
        if ({ov64, pco64, ty64, rd64, imm64, we64, il64} !== {1'b1, 64'h8000_0000_0000_0010, 3'd4, 5'd1, 64'hFFFFFFFF80000000, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rv64_lui: got v=%b pc=%h type=%0d rd=%0d imm=%h we=%b ill=%b, want 1 8000000000000010 4 1 ffffffff80000000 1 0",
                     ov64, pco64, ty64, rd64, imm64, we64, il64);
        end
        inst = 32'h0010009B;
        @(negedge clk);
        n_cmp++;
        if ({ov64, ty64, imm64, we64, il64} !== {1'b1, 3'd1, 64'd1, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL rv64_addiw: got v=%b type=%0d imm=%h we=%b ill=%b, want 1 1 1 1 0", ov64, ty64, imm64, we64, il64);
        end
        inst = 32'h00000000;
        repeat (4) @(negedge clk);
        v64 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({ov64, cnt64} !== {1'b0, 2'd3}) begin
            n_bad++;
            $display("FAIL rv64_cnt_saturate: got v=%b cnt=%0d, want 0 3", ov64, cnt64);
        end
    endtask

    initial begin
        test_reset;
        test_addi;
        test_store;
        test_back_to_back;
        test_illegal;
        test_flush;
        test_fields;
        test_rv64;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
